// File: rtl/aes_pkg.sv
// Shared AES constants and the FSM state encoding used by the iterative round controller.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_t;

endpackage

// File: rtl/aes_round_ctrl_add_round_key.sv
// addRoundKey stage: XORs the state with a round key; the result is zero unless valid is set.
module aes_round_ctrl_add_round_key
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = AES_BLOCK_W
) (
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] state,
    input  logic [DATA_WIDTH-1:0] round_key,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result
);

    assign result_valid = valid;
    assign result       = valid ? (state ^ round_key) : '0;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encrypt round controller: round-0 whitening on accept, then one external
// round per cycle, then the ciphertext is held until the downstream takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = AES_BLOCK_W,
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_valid_in,
    output logic                  ctrl_ready_out,
    input  logic [DATA_WIDTH-1:0] ctrl_data_in,
    output logic [3:0]            ctrl_round_idx,
    input  logic [DATA_WIDTH-1:0] ctrl_round_key_in,
    output logic                  ctrl_round_valid_out,
    output logic                  ctrl_round_mix_en,
    output logic [DATA_WIDTH-1:0] ctrl_round_state_out,
    input  logic [DATA_WIDTH-1:0] ctrl_round_data_in,
    output logic                  ctrl_valid_out,
    input  logic                  ctrl_ready_in,
    output logic [DATA_WIDTH-1:0] ctrl_data_out
);

    if (!(DATA_WIDTH == AES_BLOCK_W &&
          (NUM_ROUNDS == AES128_ROUNDS || NUM_ROUNDS == AES192_ROUNDS ||
           NUM_ROUNDS == AES256_ROUNDS))) begin : g_bad_params
        $error("aes_round_ctrl: unsupported DATA_WIDTH or NUM_ROUNDS");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_state_t            fsm_state;
    aes_state_t            fsm_next;
    logic [3:0]            round_cnt;
    logic [DATA_WIDTH-1:0] state_reg;
    logic                  accept;
    logic                  last_round;
    logic                  ark_valid;
    logic [DATA_WIDTH-1:0] ark_result;

    assign accept     = (fsm_state == IDLE) && ctrl_valid_in;
    assign last_round = (round_cnt == LAST_ROUND);

    // In IDLE the key store is addressed with index 0, so ctrl_round_key_in is the whitening key.
    aes_round_ctrl_add_round_key #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_add_round_key (
        .valid       (accept),
        .state       (ctrl_data_in),
        .round_key   (ctrl_round_key_in),
        .result_valid(ark_valid),
        .result      (ark_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state <= IDLE;
            round_cnt <= 4'd0;
            state_reg <= '0;
        end else begin
            fsm_state <= fsm_next;
            case (fsm_state)
                IDLE: begin
                    if (ark_valid) begin
                        state_reg <= ark_result;
                        round_cnt <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= ctrl_round_data_in;
                    if (!last_round) begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (ctrl_ready_in) begin
                        round_cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath-facing outputs are forced to zero outside ROUND; ciphertext only shows in DONE.
    always_comb begin
        fsm_next             = fsm_state;
        ctrl_ready_out       = 1'b0;
        ctrl_round_idx       = 4'd0;
        ctrl_round_valid_out = 1'b0;
        ctrl_round_mix_en    = 1'b0;
        ctrl_round_state_out = '0;
        ctrl_valid_out       = 1'b0;
        ctrl_data_out        = '0;
        case (fsm_state)
            IDLE: begin
                ctrl_ready_out = 1'b1;
                if (accept) begin
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                ctrl_round_valid_out = 1'b1;
                ctrl_round_idx       = round_cnt;
                ctrl_round_state_out = state_reg;
                ctrl_round_mix_en    = !last_round;
                if (last_round) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                ctrl_valid_out = 1'b1;
                ctrl_data_out  = state_reg;
                if (ctrl_ready_in) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES-128 and AES-256 instances driven by a behavioural round model and key schedule.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         a_valid_in, a_ready_out, a_round_valid, a_mix_en, a_valid_out, a_ready_in;
    logic [3:0]   a_round_idx;
    logic [127:0] a_data_in, a_round_key, a_round_state, a_round_data, a_data_out;
    logic         b_valid_in, b_ready_out, b_round_valid, b_mix_en, b_valid_out, b_ready_in;
    logic [3:0]   b_round_idx;
    logic [127:0] b_data_in, b_round_key, b_round_state, b_round_data, b_data_out;

    int checks = 0;
    int passed = 0;

    logic [7:0]   sbox   [256];
    logic [31:0]  w_exp  [64];
    logic [127:0] rk128  [16];
    logic [127:0] rk256  [16];

    aes_round_ctrl #(.DATA_WIDTH(AES_BLOCK_W), .NUM_ROUNDS(AES128_ROUNDS)) dut128 (
        .clk(clk), .reset(reset),
        .ctrl_valid_in(a_valid_in), .ctrl_ready_out(a_ready_out), .ctrl_data_in(a_data_in),
        .ctrl_round_idx(a_round_idx), .ctrl_round_key_in(a_round_key),
        .ctrl_round_valid_out(a_round_valid), .ctrl_round_mix_en(a_mix_en),
        .ctrl_round_state_out(a_round_state), .ctrl_round_data_in(a_round_data),
        .ctrl_valid_out(a_valid_out), .ctrl_ready_in(a_ready_in), .ctrl_data_out(a_data_out)
    );

    aes_round_ctrl #(.DATA_WIDTH(AES_BLOCK_W), .NUM_ROUNDS(AES256_ROUNDS)) dut256 (
        .clk(clk), .reset(reset),
        .ctrl_valid_in(b_valid_in), .ctrl_ready_out(b_ready_out), .ctrl_data_in(b_data_in),
        .ctrl_round_idx(b_round_idx), .ctrl_round_key_in(b_round_key),
        .ctrl_round_valid_out(b_round_valid), .ctrl_round_mix_en(b_mix_en),
        .ctrl_round_state_out(b_round_state), .ctrl_round_data_in(b_round_data),
        .ctrl_valid_out(b_valid_out), .ctrl_ready_in(b_ready_in), .ctrl_data_out(b_data_out)
    );

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int c = 1; c < 256; c++)
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] rc = 8'h01;
        for (int k = 1; k < j; k++) rc = xtime(rc);
        return rc;
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w_exp[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w_exp[i - 1];
                if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
                else if (nk > 6 && i % nk == 4) t = sub_word(t);
                w_exp[i] = w_exp[i - nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127 - 8 * i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4 * c] = a[r + 4 * ((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            if (mix) begin
                a[4*c]   = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                a[4*c+1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                a[4*c+2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
                a[4*c+3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
            end else begin
                for (int r = 0; r < 4; r++) a[4*c+r] = t[4*c+r];
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = a[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] encrypt128(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk128[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk128[r], r != 10);
        return s;
    endfunction

    // External key store and round datapath models for each instance.
    always_comb begin
        a_round_key  = rk128[a_round_idx];
        a_round_data = aes_round(a_round_state, rk128[a_round_idx], a_mix_en);
        b_round_key  = rk256[b_round_idx];
        b_round_data = aes_round(b_round_state, rk256[b_round_idx], b_mix_en);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({a_ready_out, a_valid_out, a_round_valid, a_mix_en, a_round_idx} !== 8'b1000_0000)
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {a_ready_out, a_valid_out, a_round_valid, a_mix_en, a_round_idx}, 8'b1000_0000);
        else passed++;
        checks++;
        if ({a_data_out, a_round_state} !== 256'h0)
            $display("[TB] FAIL reset_data: got %h expected 0", {a_data_out, a_round_state});
        else passed++;
        checks++;
        if ({b_ready_out, b_valid_out, b_round_valid, b_round_idx} !== 7'b100_0000)
            $display("[TB] FAIL reset_flags256: got %b expected %b",
                     {b_ready_out, b_valid_out, b_round_valid, b_round_idx}, 7'b100_0000);
        else passed++;
        a_data_in  = PT;
        a_valid_in = 1'b1;
        tick();
        a_valid_in = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        a_valid_in = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
        a_valid_in = 1'b0;
        checks++;
        if ({a_ready_out, a_valid_out, a_round_valid, a_mix_en, a_round_idx, a_data_out, a_round_state}
            !== {8'b1000_0000, 256'h0})
            $display("[TB] FAIL reset_midtraffic: got rdy=%b vld=%b rv=%b idx=%0d expected rdy=1 rest 0",
                     a_ready_out, a_valid_out, a_round_valid, a_round_idx);
        else passed++;
        tick();
        checks++;
        if ({a_ready_out, a_round_valid} !== 2'b10)
            $display("[TB] FAIL reset_stay_idle: got %b expected 10", {a_ready_out, a_round_valid});
        else passed++;
    endtask

    task automatic test_fips128();
        logic [3:0] exp_idx;
        a_ready_in = 1'b1;
        a_data_in  = PT;
        a_valid_in = 1'b1;
        checks++;
        if (a_ready_out !== 1'b1) $display("[TB] FAIL fips128_ready: got %b expected 1", a_ready_out);
        else passed++;
        tick();
        a_valid_in = 1'b0;
        a_data_in  = '0;
        checks++;
        if (a_round_state !== (PT ^ KEY128))
            $display("[TB] FAIL fips128_whiten: got %h expected %h", a_round_state, PT ^ KEY128);
        else passed++;
        for (int r = 1; r <= 10; r++) begin
            exp_idx = 4'(r);
            checks++;
            if ({a_round_valid, a_round_idx, a_mix_en, a_valid_out, a_ready_out}
                !== {1'b1, exp_idx, r != 10, 1'b0, 1'b0})
                $display("[TB] FAIL fips128_round%0d: got rv=%b idx=%0d mix=%b vo=%b ro=%b expected idx=%0d mix=%b",
                         r, a_round_valid, a_round_idx, a_mix_en, a_valid_out, a_ready_out, exp_idx, r != 10);
            else passed++;
            tick();
        end
        checks++;
        if ({a_valid_out, a_data_out} !== {1'b1, CT128})
            $display("[TB] FAIL fips128_ct: got vo=%b %h expected vo=1 %h", a_valid_out, a_data_out, CT128);
        else passed++;
        tick();
        checks++;
        if ({a_ready_out, a_valid_out, a_data_out} !== {2'b10, 128'h0})
            $display("[TB] FAIL fips128_idle: got ro=%b vo=%b %h expected ro=1 vo=0 0",
                     a_ready_out, a_valid_out, a_data_out);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        logic [127:0] pt3 = 128'h3243f6a8_885a308d_313198a2_e0370734;
        logic [127:0] exp2 = encrypt128(pt2);
        logic [127:0] exp3 = encrypt128(pt3);
        a_ready_in = 1'b0;
        a_data_in  = pt2;
        a_valid_in = 1'b1;
        tick();
        a_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        for (int k = 0; k < 5; k++) begin
            a_valid_in = 1'b1;
            a_data_in  = pt3;
            checks++;
            if ({a_valid_out, a_ready_out, a_data_out} !== {2'b10, exp2})
                $display("[TB] FAIL bp_hold%0d: got vo=%b ro=%b %h expected vo=1 ro=0 %h",
                         k, a_valid_out, a_ready_out, a_data_out, exp2);
            else passed++;
            tick();
        end
        a_ready_in = 1'b1;
        tick();
        checks++;
        if ({a_ready_out, a_round_valid, a_valid_out} !== 3'b100)
            $display("[TB] FAIL bp_release: got %b expected 100", {a_ready_out, a_round_valid, a_valid_out});
        else passed++;
        tick();
        a_valid_in = 1'b0;
        checks++;
        if ({a_round_idx, a_round_state} !== {4'd1, pt3 ^ KEY128})
            $display("[TB] FAIL bp_second_accept: got idx=%0d %h expected idx=1 %h",
                     a_round_idx, a_round_state, pt3 ^ KEY128);
        else passed++;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({a_valid_out, a_data_out} !== {1'b1, exp3})
            $display("[TB] FAIL bp_second_ct: got vo=%b %h expected vo=1 %h", a_valid_out, a_data_out, exp3);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        bit seen  = 1'b0;
        a_ready_in = 1'b1;
        a_data_in  = PT;
        a_valid_in = 1'b1;
        tick();
        a_valid_in = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (a_round_valid && a_round_idx == 4'd5) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) $display("[TB] FAIL midrun_find_idx5: got none expected idx 5 within 20 cycles");
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({a_ready_out, a_round_valid, a_round_idx, a_valid_out, a_round_state} !== {2'b10, 4'd0, 1'b0, 128'h0})
            $display("[TB] FAIL midrun_reset: got ro=%b rv=%b idx=%0d vo=%b expected ro=1 rv=0 idx=0 vo=0",
                     a_ready_out, a_round_valid, a_round_idx, a_valid_out);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            if (a_valid_out) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL midrun_no_output: got valid pulse=%b expected 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [4];
        logic [127:0] exps [4];
        int acc [4];
        int n_acc = 0;
        int n_out = 0;
        pts[0] = PT;
        pts[1] = 128'h00000000_00000000_00000000_00000000;
        pts[2] = 128'hffffffff_ffffffff_ffffffff_ffffffff;
        pts[3] = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        for (int i = 0; i < 4; i++) begin
            exps[i] = encrypt128(pts[i]);
            acc[i]  = -1;
        end
        a_ready_in = 1'b1;
        for (int c = 0; c < 60; c++) begin
            a_valid_in = (n_acc < 4);
            a_data_in  = (n_acc < 4) ? pts[n_acc] : '0;
            if (a_valid_in && a_ready_out) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (a_valid_out) begin
                if (n_out < 4) begin
                    checks++;
                    if (a_data_out !== exps[n_out])
                        $display("[TB] FAIL b2b_ct%0d: got %h expected %h", n_out, a_data_out, exps[n_out]);
                    else passed++;
                end
                n_out++;
            end
            tick();
        end
        a_valid_in = 1'b0;
        checks++;
        if (n_acc != 4 || n_out != 4)
            $display("[TB] FAIL b2b_counts: got acc=%0d out=%0d expected 4 and 4", n_acc, n_out);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 12)
                $display("[TB] FAIL b2b_interval%0d: got %0d expected 12", i, acc[i] - acc[i-1]);
            else passed++;
        end
    endtask

    task automatic test_fips256();
        logic [3:0] exp_idx;
        b_ready_in = 1'b1;
        b_data_in  = PT;
        b_valid_in = 1'b1;
        tick();
        b_valid_in = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            exp_idx = 4'(r);
            checks++;
            if ({b_round_valid, b_round_idx, b_mix_en, b_valid_out} !== {1'b1, exp_idx, r != 14, 1'b0})
                $display("[TB] FAIL fips256_round%0d: got rv=%b idx=%0d mix=%b vo=%b expected idx=%0d mix=%b",
                         r, b_round_valid, b_round_idx, b_mix_en, b_valid_out, exp_idx, r != 14);
            else passed++;
            tick();
        end
        checks++;
        if ({b_valid_out, b_data_out} !== {1'b1, CT256})
            $display("[TB] FAIL fips256_ct: got vo=%b %h expected vo=1 %h", b_valid_out, b_data_out, CT256);
        else passed++;
        tick();
        checks++;
        if ({b_ready_out, b_valid_out} !== 2'b10)
            $display("[TB] FAIL fips256_idle: got %b expected 10", {b_ready_out, b_valid_out});
        else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        a_valid_in = 1'b0;
        a_ready_in = 1'b1;
        a_data_in  = '0;
        b_valid_in = 1'b0;
        b_ready_in = 1'b1;
        b_data_in  = '0;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
        for (int r = 0; r < 16; r++) begin
            rk128[r] = '0;
            rk256[r] = '0;
        end
        expand_key({KEY128, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rk128[r] = {w_exp[4*r], w_exp[4*r+1], w_exp[4*r+2], w_exp[4*r+3]};
        expand_key(KEY256, 8, 14);
        for (int r = 0; r <= 14; r++) rk256[r] = {w_exp[4*r], w_exp[4*r+1], w_exp[4*r+2], w_exp[4*r+3]};
        $display("[TB] starting aes_round_ctrl bench");
        test_reset();
        test_fips128();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_fips256();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
